// File: rtl/snn_conv_pkg.sv
// Purpose: shared types and width helpers for the convolutional spike scheduler.
//   state_t  - scheduler FSM state encoding (also exported as a debug output)
//   ic_w     - width of the input-channel output
//   phase_w  - width of the kernel-tap output (downstream-defined width)
//   addr_w   - width of a frame coordinate
//   idx_w    - width of a flat pixel index into a square frame
package snn_conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_EMIT,
    S_IC_END,
    S_ACTIV,
    S_WAIT,
    S_STEP_END
  } state_t;

  // Never return 0 so that vectors built from it stay legal for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int ic_w(input int n);
    return $clog2(n) + 2;
  endfunction

  function automatic int phase_w(input int k);
    return $clog2(k) + 2;
  endfunction

  function automatic int addr_w(input int w);
    return clog2_min1(w);
  endfunction

  function automatic int idx_w(input int w);
    return clog2_min1(w * w);
  endfunction

endpackage

// File: rtl/conv_spike_scheduler_if.sv
// Purpose: input spike-frame handshake between a frame source and the scheduler.
//   frame_valid - source has a frame on frame_spk
//   frame_ready - scheduler can take a frame this cycle
//   frame_spk   - presynaptic spikes, bit index y*INPUT_FRAME_WIDTH+x
// Handshake: a frame is transferred on a rising clk edge where frame_valid and
// frame_ready are both 1; frame_spk must be stable while frame_valid is 1, and
// frame_valid seen while frame_ready is 0 has no effect.
interface conv_spike_scheduler_if #(
  parameter int INPUT_FRAME_WIDTH = 28
);
  logic                                           frame_valid;
  logic                                           frame_ready;
  logic [INPUT_FRAME_WIDTH*INPUT_FRAME_WIDTH-1:0] frame_spk;

  modport master (output frame_valid, output frame_spk, input frame_ready);
  modport slave  (input frame_valid, input frame_spk, output frame_ready);
endinterface

// File: rtl/spike_priority_enc.sv
// Purpose: find the lowest-index set bit of a spike mask.
//   mask_i  - spike mask
//   found_o - 1 when any bit of mask_i is set
//   index_o - index of the lowest set bit (0 when none)
module spike_priority_enc #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic [N-1:0]  mask_i,
  output logic          found_o,
  output logic [IW-1:0] index_o
);
  // Walk from the top down so the lowest set bit is the final winner.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        found_o = 1'b1;
        index_o = IW'(i);
      end
    end
  end
endmodule

// File: rtl/conv_spike_scheduler.sv
// Purpose: walks every input spike of every input channel of a time step and
// emits, per kernel tap, the output neuron it affects; then triggers the
// activation sweep and waits for it before starting the next step.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   frame_if            - spike-frame handshake (slave side)
//   en_accum            - pulse: accumulation of a time step starts
//   en_activ            - pulse: activation sweep starts
//   ic_done             - pulse: current input channel finished
//   ic                  - current input channel
//   filter_phase        - kernel tap ky*KERNEL_SIZE+kx (low bits)
//   affect_neur_addr_y/x- affected output neuron
//   neur_addr_invalid   - 1 when the address is not usable
//   last_time_step      - current step is NUM_STEPS-1
//   step_done           - pulse: end of a time step
//   dbg_state           - current FSM state
module conv_spike_scheduler
  import snn_conv_pkg::*;
#(
  parameter int IN_CHANNELS        = 2,
  parameter int KERNEL_SIZE        = 3,
  parameter int INPUT_FRAME_WIDTH  = 28,
  parameter int OUTPUT_FRAME_WIDTH = INPUT_FRAME_WIDTH - KERNEL_SIZE + 1,
  parameter int NUM_STEPS          = 25,
  parameter int ACTIV_WAIT         = OUTPUT_FRAME_WIDTH * OUTPUT_FRAME_WIDTH + 4
) (
  input  logic                               clk,
  input  logic                               rst,
  conv_spike_scheduler_if.slave              frame_if,
  output logic                               en_accum,
  output logic                               en_activ,
  output logic                               ic_done,
  output logic [ic_w(IN_CHANNELS)-1:0]       ic,
  output logic [phase_w(KERNEL_SIZE)-1:0]    filter_phase,
  output logic [addr_w(INPUT_FRAME_WIDTH)-1:0] affect_neur_addr_y,
  output logic [addr_w(INPUT_FRAME_WIDTH)-1:0] affect_neur_addr_x,
  output logic                               neur_addr_invalid,
  output logic                               last_time_step,
  output logic                               step_done,
  output state_t                             dbg_state
);
  localparam int W    = INPUT_FRAME_WIDTH;
  localparam int NPIX = W * W;
  localparam int TAPS = KERNEL_SIZE * KERNEL_SIZE;
  localparam int ICW  = ic_w(IN_CHANNELS);
  localparam int PW   = phase_w(KERNEL_SIZE);
  localparam int AW   = addr_w(W);
  localparam int IW   = idx_w(W);
  localparam int TW   = clog2_min1(TAPS);
  localparam int SW   = clog2_min1(NUM_STEPS);
  localparam int WW   = clog2_min1(ACTIV_WAIT + 1);

  state_t            state_q;
  logic [NPIX-1:0]   mask_q;
  logic [AW-1:0]     spk_y_q, spk_x_q;
  logic [TW-1:0]     tap_q;
  logic [SW-1:0]     step_q;
  logic [WW-1:0]     wait_q;
  logic [ICW-1:0]    ic_q;
  logic [PW-1:0]     phase_q;
  logic [AW-1:0]     addr_y_q, addr_x_q;
  logic              invalid_q, frame_ready_q;
  logic              en_accum_q, en_activ_q, ic_done_q, step_done_q;

  logic              enc_found;
  logic [IW-1:0]     enc_idx;

  spike_priority_enc #(.N(NPIX), .IW(IW)) u_enc (
    .mask_i  (mask_q),
    .found_o (enc_found),
    .index_o (enc_idx)
  );

  // Address for the tap about to be shown: tap 0 of the spike picked in SCAN,
  // or the following tap of the spike currently being emitted.
  int tgt_y, tgt_x, tgt_tap, ky, kx, oy, ox;
  logic nxt_invalid;
  always_comb begin
    tgt_y   = int'(spk_y_q);
    tgt_x   = int'(spk_x_q);
    tgt_tap = int'(tap_q) + 1;
    if (state_q == S_SCAN) begin
      tgt_y   = int'(enc_idx) / W;
      tgt_x   = int'(enc_idx) % W;
      tgt_tap = 0;
    end
    ky = tgt_tap / KERNEL_SIZE;
    kx = tgt_tap % KERNEL_SIZE;
    oy = tgt_y - ky;
    ox = tgt_x - kx;
    nxt_invalid = (tgt_y < ky) || (tgt_x < kx) ||
                  (oy >= OUTPUT_FRAME_WIDTH) || (ox >= OUTPUT_FRAME_WIDTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      spk_y_q       <= '0;
      spk_x_q       <= '0;
      tap_q         <= '0;
      step_q        <= '0;
      wait_q        <= '0;
      ic_q          <= '0;
      phase_q       <= '0;
      addr_y_q      <= '0;
      addr_x_q      <= '0;
      invalid_q     <= 1'b1;
      frame_ready_q <= 1'b0;
      en_accum_q    <= 1'b0;
      en_activ_q    <= 1'b0;
      ic_done_q     <= 1'b0;
      step_done_q   <= 1'b0;
    end else begin
      en_accum_q  <= 1'b0;
      en_activ_q  <= 1'b0;
      ic_done_q   <= 1'b0;
      step_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          en_accum_q    <= 1'b1;
          ic_q          <= '0;
          frame_ready_q <= 1'b1;
          state_q       <= S_LOAD;
        end
        S_LOAD: begin
          if (frame_if.frame_valid) begin
            mask_q        <= frame_if.frame_spk;
            frame_ready_q <= 1'b0;
            state_q       <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (enc_found) begin
            mask_q[enc_idx] <= 1'b0;
            spk_y_q   <= AW'(tgt_y);
            spk_x_q   <= AW'(tgt_x);
            tap_q     <= '0;
            phase_q   <= PW'(tgt_tap);
            addr_y_q  <= AW'(oy);
            addr_x_q  <= AW'(ox);
            invalid_q <= nxt_invalid;
            state_q   <= S_EMIT;
          end else begin
            ic_done_q <= 1'b1;
            state_q   <= S_IC_END;
          end
        end
        S_EMIT: begin
          if (tap_q == TW'(TAPS - 1)) begin
            invalid_q <= 1'b1;
            state_q   <= S_SCAN;
          end else begin
            tap_q     <= tap_q + 1'b1;
            phase_q   <= PW'(tgt_tap);
            addr_y_q  <= AW'(oy);
            addr_x_q  <= AW'(ox);
            invalid_q <= nxt_invalid;
          end
        end
        S_IC_END: begin
          if (ic_q == ICW'(IN_CHANNELS - 1)) begin
            en_activ_q <= 1'b1;
            state_q    <= S_ACTIV;
          end else begin
            ic_q          <= ic_q + 1'b1;
            frame_ready_q <= 1'b1;
            state_q       <= S_LOAD;
          end
        end
        S_ACTIV: begin
          wait_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == WW'(ACTIV_WAIT - 1)) begin
            step_done_q <= 1'b1;
            state_q     <= S_STEP_END;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_STEP_END: begin
          step_q  <= (step_q == SW'(NUM_STEPS - 1)) ? '0 : step_q + 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign frame_if.frame_ready = frame_ready_q;
  assign en_accum             = en_accum_q;
  assign en_activ             = en_activ_q;
  assign ic_done              = ic_done_q;
  assign step_done            = step_done_q;
  assign ic                   = ic_q;
  assign filter_phase         = phase_q;
  assign affect_neur_addr_y   = addr_y_q;
  assign affect_neur_addr_x   = addr_x_q;
  assign neur_addr_invalid    = invalid_q;
  assign last_time_step       = (step_q == SW'(NUM_STEPS - 1));
  assign dbg_state            = state_q;
endmodule

// File: tb/tb_conv_spike_scheduler.sv
module tb_conv_spike_scheduler;
  import snn_conv_pkg::*;

  localparam int W   = 4;
  localparam int K   = 3;
  localparam int OW  = 2;
  localparam int NIC = 2;
  localparam int NS  = 2;
  localparam int AWT = 8;

  // pulse vector layout: {frame_ready, en_accum, ic_done, en_activ, step_done}
  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_RDY  = 5'b10000;
  localparam logic [4:0] P_ACC  = 5'b01000;
  localparam logic [4:0] P_ICD  = 5'b00100;
  localparam logic [4:0] P_ACT  = 5'b00010;
  localparam logic [4:0] P_SD   = 5'b00001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_spike_scheduler_if #(.INPUT_FRAME_WIDTH(W)) fif ();

  logic       en_accum, en_activ, ic_done, neur_addr_invalid, last_time_step, step_done;
  logic [2:0] ic;
  logic [3:0] filter_phase;
  logic [1:0] addr_y, addr_x;
  state_t     dbg_state;

  conv_spike_scheduler #(
    .IN_CHANNELS(NIC), .KERNEL_SIZE(K), .INPUT_FRAME_WIDTH(W),
    .OUTPUT_FRAME_WIDTH(OW), .NUM_STEPS(NS), .ACTIV_WAIT(AWT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .frame_if           (fif),
    .en_accum           (en_accum),
    .en_activ           (en_activ),
    .ic_done            (ic_done),
    .ic                 (ic),
    .filter_phase       (filter_phase),
    .affect_neur_addr_y (addr_y),
    .affect_neur_addr_x (addr_x),
    .neur_addr_invalid  (neur_addr_invalid),
    .last_time_step     (last_time_step),
    .step_done          (step_done),
    .dbg_state          (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] pulses();
    return {fif.frame_ready, en_accum, ic_done, en_activ, step_done};
  endfunction

  // Reference: a tap (ky,kx) of input pixel (y,x) reaches output neuron (oy,ox)
  // when oy+ky==y and ox+kx==x for some neuron inside the output frame.
  function automatic bit tap_hits(input int idx, input int tap, output int ay, output int ax);
    int y, x, ky, kx;
    y = idx / W; x = idx % W; ky = tap / K; kx = tap % K;
    ay = 0; ax = 0;
    for (int oy = 0; oy < OW; oy++)
      for (int ox = 0; ox < OW; ox++)
        if (oy + ky == y && ox + kx == x) begin
          ay = oy; ax = ox;
          return 1'b1;
        end
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic junk();
    fif.frame_valid = 1'($urandom_range(0, 1));
    fif.frame_spk   = 16'($urandom);
  endtask

  task automatic check_quiet(input string tag, input logic [4:0] exp_p, input int c);
    check_val({tag, "_pulses"}, 32'(pulses()), 32'(exp_p));
    check_val({tag, "_inv"}, 32'(neur_addr_invalid), 32'd1);
    check_val({tag, "_ic"}, 32'(ic), 32'(c));
  endtask

  // Expected per-tap record {valid, phase, y, x} for one spike.
  task automatic emit_spike(input int idx);
    int ay, ax;
    bit hit;
    for (int tap = 0; tap < K * K; tap++) begin
      hit = tap_hits(idx, tap, ay, ax);
      exp_q.push_back({hit, 8'(tap), 8'(ay), 8'(ax)});
    end
  endtask

  // Called on the negedge of a LOAD cycle already checked. Runs one channel.
  task automatic run_channel(input logic [15:0] spk, input int c, input int s, input bit rst_mid);
    logic [31:0] e;
    int nwait;
    nwait = $urandom_range(0, 2);
    repeat (nwait) begin
      @(negedge clk);
      check_quiet("load_hold", P_RDY, c);
    end
    fif.frame_valid = 1'b1;
    fif.frame_spk   = spk;
    for (int idx = 0; idx < W * W; idx++) begin
      if (spk[idx]) begin
        @(negedge clk);
        if (rst_mid) fif.frame_valid = 1'b0; else junk();
        check_quiet("scan", P_NONE, c);
        emit_spike(idx);
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          @(negedge clk);
          if (!rst_mid) junk();
          check_val("emit_inv", 32'(neur_addr_invalid), 32'(!e[24]));
          check_val("emit_pulses", 32'(pulses()), 32'(P_NONE));
          if (e[24]) begin
            check_val("emit_phase", 32'(filter_phase), 32'(e[23:16]));
            check_val("emit_y", 32'(addr_y), 32'(e[15:8]));
            check_val("emit_x", 32'(addr_x), 32'(e[7:0]));
          end
          if (rst_mid && e[23:16] == 8'd4) begin
            rst = 1'b1;
            exp_q.delete();
            return;
          end
        end
      end
    end
    @(negedge clk);
    junk();
    check_quiet("scan_empty", P_NONE, c);
    @(negedge clk);
    fif.frame_valid = 1'b0;
    check_quiet("ic_end", P_ICD, c);
    if (c < NIC - 1) begin
      @(negedge clk);
      check_quiet("load_next", P_RDY, c + 1);
    end else begin
      @(negedge clk);
      junk();
      check_quiet("activ", P_ACT, c);
      repeat (AWT) begin
        @(negedge clk);
        junk();
        check_quiet("wait", P_NONE, c);
      end
      @(negedge clk);
      fif.frame_valid = 1'b0;
      check_quiet("step_end", P_SD, c);
      check_val("lts_step", 32'(last_time_step), 32'((s % NS) == NS - 1));
      @(negedge clk);
      check_val("idle_pulses", 32'(pulses()), 32'(P_NONE));
      check_val("lts_next", 32'(last_time_step), 32'(((s + 1) % NS) == NS - 1));
      @(negedge clk);
      check_quiet("load_first", P_RDY | P_ACC, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] frames[10];

  initial begin
    rst = 1'b1;
    fif.frame_valid = 1'b0;
    fif.frame_spk   = '0;
    frames[0] = 16'h0020; frames[1] = 16'h0000;   // spike at (1,1), then empty
    frames[2] = 16'h0000; frames[3] = 16'h0000;   // both empty
    frames[4] = 16'h8001; frames[5] = 16'h0024;   // corners; bits 2 and 5
    for (int i = 6; i < 10; i++) frames[i] = 16'($urandom);

    repeat (3) @(negedge clk);
    check_quiet("rst", P_NONE, 0);
    check_val("rst_phase", 32'(filter_phase), 32'd0);
    check_val("rst_y", 32'(addr_y), 32'd0);
    check_val("rst_x", 32'(addr_x), 32'd0);
    check_val("rst_lts", 32'(last_time_step), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check_quiet("load_first", P_RDY | P_ACC, 0);

    for (int s = 0; s < 5; s++)
      for (int c = 0; c < NIC; c++)
        run_channel(frames[s * NIC + c], c, s, 1'b0);

    // Step 5 is the last step of its inference; abort it in the middle of a spike.
    check_val("pre_rst_lts", 32'(last_time_step), 32'd1);
    run_channel(16'h0020, 0, 5, 1'b1);
    @(negedge clk);
    check_quiet("mid_rst", P_NONE, 0);
    check_val("mid_rst_phase", 32'(filter_phase), 32'd0);
    check_val("mid_rst_y", 32'(addr_y), 32'd0);
    check_val("mid_rst_x", 32'(addr_x), 32'd0);
    check_val("mid_rst_lts", 32'(last_time_step), 32'd0);
    @(negedge clk);
    check_quiet("rst_hold", P_NONE, 0);
    rst = 1'b0;
    @(negedge clk);
    check_quiet("load_after_rst", P_RDY | P_ACC, 0);
    run_channel(16'($urandom), 0, 0, 1'b0);
    run_channel(16'($urandom), 1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
